alu_mdu: RTL and testbench

//  Parametrised execute unit and successor to the single-cycle ALU. Completes the RV32I ALU op set
//  (shifts, SLT/SLTU) and adds an iterative RV32M multiply/divide datapath.

---
 rtl/alu_mdu_if.sv | 25 ++
 rtl/alu_mdu.sv | 169 ++++++++++++++++
 tb/tb_alu_mdu.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_if.sv
// Execute-unit bus: operation request handshake and result handshake.
interface alu_mdu_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  InValid;
    logic                  InReady;
    logic [4:0]            ALUControl;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  OutValid;
    logic                  OutReady;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  ZeroFlag;
    logic                  NegativeFlag;

    modport master (
        output InValid, ALUControl, SrcA, SrcB, OutReady,
        input  InReady, OutValid, ALUResult, ZeroFlag, NegativeFlag
    );

    modport slave (
        input  InValid, ALUControl, SrcA, SrcB, OutReady,
        output InReady, OutValid, ALUResult, ZeroFlag, NegativeFlag
    );
endinterface

// File: rtl/alu_mdu.sv
// RV32I ALU plus iterative RV32M multiply/divide with valid/ready on both sides.
module alu_mdu #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    alu_mdu_if.slave bus
);
    localparam int unsigned W   = DATA_WIDTH;
    localparam int unsigned ShW = $clog2(DATA_WIDTH);
    localparam logic [ShW-1:0] LastStep = ShW'(W - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [ShW-1:0] cnt_q, cnt_d;
    logic [2*W-1:0] prod_q, prod_d;  // mul: {acc, multiplier}; div: {rem, dividend/quotient}
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   a_q, a_d;
    logic           qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [W-1:0]   res_q, res_d;
    logic           zero_q, zero_d, neg_q, neg_d;

    logic           a_signed, b_signed, sa, sb;
    logic [W-1:0]   mag_a, mag_b, alu_res;
    logic [ShW-1:0] shamt;
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic [2*W-1:0] step_prod, mul_full;
    logic [W-1:0]   quo, rem, mdu_res;

    always_comb begin
        shamt = bus.SrcB[ShW-1:0];
        case (bus.ALUControl)
            5'd0:    alu_res = bus.SrcA + bus.SrcB;
            5'd1:    alu_res = bus.SrcA - bus.SrcB;
            5'd2:    alu_res = bus.SrcA & bus.SrcB;
            5'd3:    alu_res = bus.SrcA | bus.SrcB;
            5'd4:    alu_res = bus.SrcA ^ bus.SrcB;
            5'd5:    alu_res = bus.SrcA << shamt;
            5'd6:    alu_res = bus.SrcA >> shamt;
            5'd7:    alu_res = $unsigned($signed(bus.SrcA) >>> shamt);
            5'd8:    alu_res = {{(W-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
            5'd9:    alu_res = {{(W-1){1'b0}}, bus.SrcA < bus.SrcB};
            default: alu_res = '0;
        endcase
    end

    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
    always_comb begin
        a_signed = (bus.ALUControl == 5'd17) || (bus.ALUControl == 5'd18) ||
                   (bus.ALUControl == 5'd20) || (bus.ALUControl == 5'd22);
        b_signed = (bus.ALUControl == 5'd17) || (bus.ALUControl == 5'd20) ||
                   (bus.ALUControl == 5'd22);
        sa       = a_signed & bus.SrcA[W-1];
        sb       = b_signed & bus.SrcB[W-1];
        mag_a    = sa ? -bus.SrcA : bus.SrcA;
        mag_b    = sb ? -bus.SrcB : bus.SrcB;
    end

    always_comb begin
        mul_sum   = {1'b0, prod_q[2*W-1:W]} + {1'b0, (prod_q[0] ? b_q : {W{1'b0}})};
        div_shift = prod_q[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, b_q};
        if (op_q[2]) begin
            step_prod = div_diff[W] ? {div_shift[W-1:0], prod_q[W-2:0], 1'b0}
                                    : {div_diff[W-1:0], prod_q[W-2:0], 1'b1};
        end else begin
            step_prod = {mul_sum, prod_q[W-1:1]};
        end

        mul_full = qneg_q ? -step_prod : step_prod;
        quo      = dz_q ? {W{1'b1}} : (qneg_q ? -step_prod[W-1:0] : step_prod[W-1:0]);
        rem      = dz_q ? a_q : (rneg_q ? -step_prod[2*W-1:W] : step_prod[2*W-1:W]);
        case (op_q)
            3'd0:          mdu_res = mul_full[W-1:0];
            3'd1, 3'd2, 3'd3: mdu_res = mul_full[2*W-1:W];
            3'd4, 3'd5:    mdu_res = quo;
            default:       mdu_res = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        b_d     = b_q;
        a_d     = a_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        res_d   = res_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            StIdle: begin
                if (bus.InValid) begin
                    op_d = bus.ALUControl[2:0];
                    if (bus.ALUControl[4:3] == 2'b10) begin
                        prod_d  = {{W{1'b0}}, mag_a};
                        b_d     = mag_b;
                        a_d     = bus.SrcA;
                        qneg_d  = sa ^ sb;
                        rneg_d  = sa;
                        dz_d    = (bus.SrcB == '0);
                        cnt_d   = '0;
                        state_d = StBusy;
                    end else begin
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        neg_d   = alu_res[W-1];
                        state_d = StDone;
                    end
                end
            end
            StBusy: begin
                prod_d = step_prod;
                cnt_d  = cnt_q + ShW'(1);
                if (cnt_q == LastStep) begin
                    res_d   = mdu_res;
                    zero_d  = (mdu_res == '0);
                    neg_d   = mdu_res[W-1];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.OutReady) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            b_q     <= '0;
            a_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            b_q     <= b_d;
            a_q     <= a_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.InReady      = (state_q == StIdle);
    assign bus.OutValid     = (state_q == StDone);
    assign bus.ALUResult    = res_q;
    assign bus.ZeroFlag     = zero_q;
    assign bus.NegativeFlag = neg_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed corner cases plus random ops against a reference model.
module tb_alu_mdu;
    localparam int unsigned W   = 32;
    localparam int unsigned Lat = W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_mdu_if #(.DATA_WIDTH(W)) bus ();
    alu_mdu #(.DATA_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int unsigned acc;
        int unsigned lat;
        logic [4:0]  op;
    } exp_t;

    exp_t        scb[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned last_out_cyc = 0;
    bit          hold_ready = 1'b0;
    logic [4:0]  op_tab [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                                 5'd12, 5'd27};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.OutReady = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int          sa, sb2;
        longint      ps;
        logic [63:0] pu;
        int unsigned sh;
        sa  = a;
        sb2 = b;
        sh  = b % 32;
        pu  = {32'b0, a} * {32'b0, b};
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << sh;
            5'd6:  return a >> sh;
            5'd7:  return sa >>> sh;
            5'd8:  return (sa < sb2) ? 32'd1 : 32'd0;
            5'd9:  return (a < b) ? 32'd1 : 32'd0;
            5'd16: return pu[31:0];
            5'd17: begin ps = longint'(sa) * longint'(sb2); return ps[63:32]; end
            5'd18: begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
            5'd19: return pu[63:32];
            5'd20: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb2;
            end
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb2;
            end
            5'd23: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the scoreboard on each new result and checks it stays held until taken.
    exp_t cur;
    bit   have = 1'b0;
    bit   in_out = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_out = 1'b0;
        end else if (bus.OutValid === 1'b1) begin
            if (!in_out) begin
                in_out = 1'b1;
                if (scb.size() == 0) begin
                    have = 1'b0;
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h want no result", bus.ALUResult);
                end else begin
                    cur  = scb.pop_front();
                    have = 1'b1;
                    chk($sformatf("result_op%0d", cur.op), bus.ALUResult, cur.res);
                    chk("zero_flag", {31'b0, bus.ZeroFlag}, {31'b0, cur.res == 32'd0});
                    chk("neg_flag", {31'b0, bus.NegativeFlag}, {31'b0, cur.res[31]});
                    chk($sformatf("latency_op%0d", cur.op), cyc - cur.acc, cur.lat);
                end
            end else if (have) begin
                chk("held_result", bus.ALUResult, cur.res);
            end
            if (bus.OutReady === 1'b1) begin
                in_out       = 1'b0;
                last_out_cyc = cyc;
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit track, output int unsigned acc);
        exp_t e;
        int   guard = 0;
        bit   ok = 1'b0;
        acc            = 0;
        bus.InValid    = 1'b1;
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        while (!ok && guard < 300) begin
            @(negedge clk);
            if (bus.InReady === 1'b1) ok = 1'b1;
            else guard++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout_op%0d: got no InReady want accept", op);
            bus.InValid = 1'b0;
            return;
        end
        acc = cyc;
        if (track) begin
            e.res = exp;
            e.acc = cyc;
            e.lat = (op >= 5'd16 && op <= 5'd23) ? Lat : 1;
            e.op  = op;
            scb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.InValid    = 1'b0;
        bus.ALUControl = 5'($urandom);
        bus.SrcA       = $urandom;
        bus.SrcB       = $urandom;
    endtask

    task automatic drain();
        int g = 0;
        while ((scb.size() != 0 || bus.OutValid === 1'b1) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", scb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        int unsigned acc;
        issue(op, a, b, exp, 1'b1, acc);
    endtask

    initial begin
        int unsigned acc1, acc2;
        bus.InValid    = 1'b0;
        bus.ALUControl = '0;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_inready", {31'b0, bus.InReady}, 32'd1);
        chk("reset_outvalid", {31'b0, bus.OutValid}, 32'd0);
        chk("reset_result", bus.ALUResult, 32'd0);
        chk("reset_zero", {31'b0, bus.ZeroFlag}, 32'd0);
        chk("reset_neg", {31'b0, bus.NegativeFlag}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset mid-divide: the op must vanish without a result.
        issue(5'd20, 32'd100, 32'd7, 32'd0, 1'b0, acc1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("busy_inready", {31'b0, bus.InReady}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy_inready", {31'b0, bus.InReady}, 32'd1);
        chk("rst_busy_outvalid", {31'b0, bus.OutValid}, 32'd0);
        chk("rst_busy_result", bus.ALUResult, 32'd0);
        chk("rst_busy_zero", {31'b0, bus.ZeroFlag}, 32'd0);
        chk("rst_busy_neg", {31'b0, bus.NegativeFlag}, 32'd0);
        repeat (45) @(posedge clk);
        #1;

        run(5'd0,  32'h7FFF_FFFF, 32'd1,        32'h8000_0000);
        run(5'd1,  32'd5,         32'd5,        32'd0);
        run(5'd7,  32'h8000_0000, 32'h21,       32'hC000_0000);
        run(5'd8,  32'hFFFF_FFFF, 32'd1,        32'd1);
        run(5'd9,  32'hFFFF_FFFF, 32'd1,        32'd0);
        run(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        run(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        run(5'd20, 32'd7,         32'd0,        32'hFFFF_FFFF);
        run(5'd22, 32'd7,         32'd0,        32'd7);
        run(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run(5'd22, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
        run(5'd13, 32'd3,         32'd4,        32'd0);
        drain();

        // Back-pressure: result held five cycles while the next op waits with InValid high.
        hold_ready = 1'b1;
        @(posedge clk);
        #2;
        issue(5'd0, 32'd3, 32'd4, 32'd7, 1'b1, acc1);
        fork
            issue(5'd1, 32'd9, 32'd4, 32'd5, 1'b1, acc2);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_inready", {31'b0, bus.InReady}, 32'd0);
                    chk("bp_outvalid", {31'b0, bus.OutValid}, 32'd1);
                end
                hold_ready = 1'b0;
            end
        join
        chk("bp_accept_after_idle", acc2, last_out_cyc + 1);
        drain();

        for (int i = 0; i < 60; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = op_tab[$urandom_range(0, 19)];
            a  = pick();
            b  = pick();
            run(op, a, b, model(op, a, b));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end
endmodule
